// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// mem_bus_arbiter
// This module shares one synchronous RAM between instruction fetch and the
// data stage. Instruction fetch cannot be starved indefinitely.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_stall,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_w_mask,
  input  logic [3:0]  d_r_mask,
  output logic        d_gnt,
  output logic        d_stall,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_wmask,
  input  logic [31:0] ram_rdata
);

  localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D_RD = 2'd2,
    OWN_D_WR = 2'd3
  } owner_t;

  owner_t     r_owner;
  logic [3:0] r_starve_cnt;
  logic [3:0] r_rmask;
  logic       w_if_forced;
  logic [31:0] w_lane_mask;

  // Grants are gated by rst so every output reads zero while reset is held.
  assign w_if_forced = if_req & (r_starve_cnt == C_LIMIT);
  assign if_gnt      = ~rst & if_req & (~d_req | w_if_forced);
  assign d_gnt       = ~rst & d_req & ~w_if_forced;
  assign if_stall    = ~rst & if_req & ~if_gnt;
  assign d_stall     = ~rst & d_req & ~d_gnt;

  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = 32'd0;
    ram_wdata = 32'd0;
    ram_wmask = 4'd0;
    if (if_gnt) begin
      ram_ce   = 1'b1;
      ram_addr = {if_addr[31:2], 2'b00};
    end else if (d_gnt) begin
      ram_ce    = 1'b1;
      ram_we    = d_wr;
      ram_addr  = {d_addr[31:2], 2'b00};
      ram_wdata = d_wdata;
      ram_wmask = d_wr ? d_w_mask : 4'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner      <= OWN_NONE;
      r_starve_cnt <= 4'd0;
      r_rmask      <= 4'd0;
    end else begin
      if (if_gnt)
        r_owner <= OWN_IF;
      else if (d_gnt)
        r_owner <= d_wr ? OWN_D_WR : OWN_D_RD;
      else
        r_owner <= OWN_NONE;

      if (d_gnt && !d_wr)
        r_rmask <= d_r_mask;

      if (if_gnt || !if_req)
        r_starve_cnt <= 4'd0;
      else if (d_gnt && r_starve_cnt != C_LIMIT)
        r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  assign w_lane_mask = {{8{r_rmask[3]}}, {8{r_rmask[2]}}, {8{r_rmask[1]}}, {8{r_rmask[0]}}};

  assign if_valid = (r_owner == OWN_IF);
  assign if_rdata = if_valid ? ram_rdata : 32'd0;
  assign d_valid  = (r_owner == OWN_D_RD) || (r_owner == OWN_D_WR);
  assign d_rdata  = (r_owner == OWN_D_RD) ? (ram_rdata & w_lane_mask) : 32'd0;

endmodule

`default_nettype wire
